// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises one WORD_BYTES_P-byte word per upstream handshake
// onto an AXI-stream byte port, with selectable byte order and an optional
// idle gap between data bytes.
//
// Optional feature macro: UART_WORD_TX_CHECKSUM_EN
//   defined   -> each frame carries one extra XOR checksum byte, which holds tlast
//   undefined -> frames are exactly WORD_BYTES_P bytes, tlast on the last data byte
//
// All outputs come from registers or from decoding registered state, so no
// combinational path exists from valid_i or m_axis_tready to any output.
module uart_word_tx #(
    parameter int unsigned WORD_BYTES_P = 4,
    parameter int unsigned MSB_FIRST_P  = 0,
    parameter int unsigned GAP_CYCLES_P = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [8*WORD_BYTES_P-1:0]   word_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [7:0]                  m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        busy_o,
    output logic [15:0]                 bytes_sent_o
);

    localparam int unsigned WORD_W = 8 * WORD_BYTES_P;
    localparam int unsigned IDX_W  = (WORD_BYTES_P > 1) ? $clog2(WORD_BYTES_P) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES_P - 1);
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES_P > 0) ? 8'(GAP_CYCLES_P - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
`ifdef UART_WORD_TX_CHECKSUM_EN
        GAP  = 2'd2,
        CSUM = 2'd3
`else
        GAP  = 2'd2
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          gap_q, gap_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                ready_q, ready_d;
`ifdef UART_WORD_TX_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    // The byte on the wire always sits at one fixed end of the shift
    // register; consumed bytes are shifted out, leaving zeros behind, so
    // the data output reads 0x00 once a frame has drained.
    logic [7:0]          cur_byte;
    logic [WORD_W-1:0]   shift_next;
    logic                last_byte;

    assign cur_byte   = (MSB_FIRST_P != 0) ? shift_q[WORD_W-1 -: 8] : shift_q[7:0];
    assign shift_next = (MSB_FIRST_P != 0) ? (shift_q << 8) : (shift_q >> 8);
    assign last_byte  = (idx_q == LAST_IDX);

    // State register and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
`ifdef UART_WORD_TX_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
`ifdef UART_WORD_TX_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next-state logic: word capture, byte stepping, gap countdown and
    // checksum emission; ready is precomputed so it is a plain register.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
`ifdef UART_WORD_TX_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
                    shift_d = word_i;
                    idx_d   = '0;
`ifdef UART_WORD_TX_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = SEND;
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q + 16'd1;
`ifdef UART_WORD_TX_CHECKSUM_EN
                    csum_d  = csum_q ^ cur_byte;
`endif
                    if (last_byte) begin
                        idx_d = '0;
`ifdef UART_WORD_TX_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (GAP_CYCLES_P > 0) begin
                            gap_d   = GAP_LOAD;
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
`ifdef UART_WORD_TX_CHECKSUM_EN
            CSUM: begin
                if (m_axis_tready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_d = (state_d == IDLE);

    // Output decode from registered state only.
    always_comb begin
        ready_o       = ready_q;
        busy_o        = (state_q != IDLE);
        bytes_sent_o  = cnt_q;
        m_axis_tdata  = cur_byte;
`ifdef UART_WORD_TX_CHECKSUM_EN
        m_axis_tvalid = (state_q == SEND) || (state_q == CSUM);
        m_axis_tlast  = (state_q == CSUM);
        if (state_q == CSUM) begin
            m_axis_tdata = csum_q;
        end
`else
        m_axis_tvalid = (state_q == SEND);
        m_axis_tlast  = (state_q == SEND) && last_byte;
`endif
    end

endmodule
